// File: rtl/serial_arith_pkg.sv
// ----------------------------------------------------------------------------
// serial_arith_pkg
// Shared definitions for the bit-serial add/subtract controller:
//   - state_e      : controller state encoding (IDLE / RUN / DONE)
//   - OP_ADD/OP_SUB: encoding of the op_sub request bit
//   - DEFAULT_WIDTH: default operand/result width
// ----------------------------------------------------------------------------
package serial_arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/serial_fa_cell.sv
// ----------------------------------------------------------------------------
// serial_fa_cell
// 1-bit combinational full adder, reused every cycle by the serial controller.
// Ports:
//   a, b  : operand bits
//   cin   : carry in
//   s     : sum bit
//   co    : carry out
// ----------------------------------------------------------------------------
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ cin;
    assign co = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// ----------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial add/subtract unit. One full-adder cell is applied LSB-first over
// WIDTH cycles; the result and flags are registered at the last bit.
// Ports:
//   clk, reset : clock (rising edge), asynchronous active-high reset
//   start      : request, accepted in IDLE or DONE (abort has priority)
//   op_sub     : 0 = A+B, 1 = A-B (sampled with start)
//   a_in, b_in : operands (sampled with start)
//   abort      : cancel the in-flight operation, return to IDLE
//   busy       : high while the operation is running
//   done       : one-cycle pulse, result and flags valid
//   result     : sum/difference, held until the next completed operation
//   cout       : raw carry out of the MSB (subtract: 1 = no borrow)
//   ovf        : signed overflow
//   zero       : result == 0
// ----------------------------------------------------------------------------
module serial_add_ctrl
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cmsb_q, cmsb_d;     // carry into the MSB, for overflow
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   res_sh_q, res_sh_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               fa_s;
    logic               fa_co;
    logic [WIDTH-1:0]   res_next;

    serial_fa_cell u_fa (
        .a   (a_sh_q[0]),
        .b   (b_sh_q[0]),
        .cin (carry_q),
        .s   (fa_s),
        .co  (fa_co)
    );

    // Sum bits enter at the MSB so the LSB ends up at bit 0 after WIDTH shifts.
    assign res_next = {fa_s, res_sh_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cmsb_d   = cmsb_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    // Subtract as A + ~B + 1: invert B and seed the carry.
                    a_sh_d   = a_in;
                    b_sh_d   = (op_sub == OP_SUB) ? ~b_in : b_in;
                    carry_d  = (op_sub == OP_SUB);
                    cnt_d    = '0;
                    res_sh_d = '0;
                    state_d  = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    a_sh_d   = a_sh_q >> 1;
                    b_sh_d   = b_sh_q >> 1;
                    res_sh_d = res_next;
                    carry_d  = fa_co;
                    if (cnt_q == CNT_W'(WIDTH - 2)) begin
                        cmsb_d = fa_co;
                    end
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        result_d = res_next;
                        cout_d   = fa_co;
                        ovf_d    = cmsb_q ^ fa_co;
                        zero_d   = (res_next == '0);
                        state_d  = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cmsb_q   <= 1'b0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cmsb_q   <= cmsb_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;
    assign zero   = zero_q;

endmodule
